// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_fill_arbiter
//  Purpose  : Shares one pipelined memory between the I-cache and D-cache miss
//             handlers. Sequences block fills as back-to-back pipelined reads,
//             and D-side single-word write-throughs.
//  Config   : MEM_ARB_RR_EN - when defined, simultaneous requests are granted
//             round-robin. Otherwise D has fixed priority over I.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_fill_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    localparam int IDX_W          = $clog2(WORDS_PER_BLOCK),
    localparam int DATA_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // I-cache side
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_fill_valid,
    output logic [IDX_W-1:0]      i_fill_idx,
    output logic [DATA_W-1:0]     i_fill_data,
    output logic                  i_done,
    // D-cache side
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_fill_valid,
    output logic [IDX_W-1:0]      d_fill_idx,
    output logic [DATA_W-1:0]     d_fill_data,
    output logic                  d_done,
    // Memory side
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid
);

    // Byte-offset bits inside a block, and the halfword-alignment bit.
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_owner_d;     // 1 = D side owns the current transaction
    logic [ADDR_WIDTH-1:0]   r_base;        // block-aligned base of the current fill
    logic [IDX_W-1:0]        r_issue_cnt;
    logic [IDX_W-1:0]        r_rcv_cnt;
    logic                    r_mem_en;
    logic                    r_mem_wr;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic                    r_wr_done;

    logic                    w_tie_pick_d;
    logic                    w_grant_d;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [ADDR_WIDTH-1:0]   w_sel_base;
    logic [IDX_W-1:0]        w_next_issue;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic                    w_rd_busy;
    logic                    w_ret;
    logic                    w_last_ret;

`ifdef MEM_ARB_RR_EN
    logic r_last_d;     // 1 = D was granted most recently

    // Remember which side won the last grant so a tie goes to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && (i_req || d_req)) begin
            r_last_d <= w_grant_d;
        end
    end

    assign w_tie_pick_d = ~r_last_d;
`else
    assign w_tie_pick_d = 1'b1;
`endif

    // Arbitration: a lone request always wins; a tie is resolved by w_tie_pick_d.
    always_comb begin
        w_grant_d = 1'b0;
        if (d_req && i_req) begin
            w_grant_d = w_tie_pick_d;
        end else begin
            w_grant_d = d_req;
        end
    end

    assign w_sel_addr   = w_grant_d ? d_addr : i_addr;
    assign w_sel_base   = w_sel_addr & ~OFF_MASK;
    assign w_next_issue = r_issue_cnt + 1'b1;
    assign w_next_addr  = r_base | {{(ADDR_WIDTH - IDX_W - 1){1'b0}}, w_next_issue, 1'b0};

    // Returns only count while a read is in flight; stray returns are ignored.
    assign w_rd_busy  = (r_state == RD_ISSUE) || (r_state == RD_DRAIN);
    assign w_ret      = w_rd_busy && mem_rvalid;
    assign w_last_ret = w_ret && (r_state == RD_DRAIN) && (r_rcv_cnt == LAST_IDX);

    // Main sequencer: arbitration, write, read issue and drain, with registered memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner_d   <= 1'b0;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wr_done   <= 1'b0;
        end else begin
            if (w_ret) begin
                r_rcv_cnt <= r_rcv_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_req || d_req) begin
                        r_owner_d   <= w_grant_d;
                        r_base      <= w_sel_base;
                        r_issue_cnt <= '0;
                        r_rcv_cnt   <= '0;
                        r_mem_en    <= 1'b1;
                        if (w_grant_d && d_wr) begin
                            r_state     <= WRITE;
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= d_addr & ~WORD_MASK;
                            r_mem_wdata <= d_wdata;
                            r_wr_done   <= 1'b1;
                        end else begin
                            r_state    <= RD_ISSUE;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= w_sel_base;
                        end
                    end
                end
                WRITE: begin
                    r_state     <= IDLE;
                    r_mem_en    <= 1'b0;
                    r_mem_wr    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_wr_done   <= 1'b0;
                end
                RD_ISSUE: begin
                    if (r_issue_cnt == LAST_IDX) begin
                        r_state    <= RD_DRAIN;
                        r_mem_en   <= 1'b0;
                        r_mem_addr <= '0;
                    end else begin
                        r_issue_cnt <= w_next_issue;
                        r_mem_addr  <= w_next_addr;
                    end
                end
                RD_DRAIN: begin
                    if (w_last_ret) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Returned words are forwarded in the same cycle to the owner only.
    assign i_fill_valid = w_ret & ~r_owner_d;
    assign i_fill_idx   = i_fill_valid ? r_rcv_cnt : '0;
    assign i_fill_data  = i_fill_valid ? mem_rdata : '0;
    assign i_done       = w_last_ret & ~r_owner_d;

    assign d_fill_valid = w_ret & r_owner_d;
    assign d_fill_idx   = d_fill_valid ? r_rcv_cnt : '0;
    assign d_fill_data  = d_fill_valid ? mem_rdata : '0;
    assign d_done       = r_wr_done | (w_last_ret & r_owner_d);

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_fill_arbiter
//  Purpose  : Scoreboard bench for mem_fill_arbiter with a behavioural memory
//             and reference image. Honors MEM_ARB_RR_EN for tie expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_fill_valid, i_done, d_fill_valid, d_done;
    logic [2:0]  i_fill_idx, d_fill_idx;
    logic [15:0] i_fill_data, d_fill_data;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_fill_valid(i_fill_valid),
        .i_fill_idx(i_fill_idx), .i_fill_data(i_fill_data), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_fill_valid(d_fill_valid), .d_fill_idx(d_fill_idx),
        .d_fill_data(d_fill_data), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory: 1-cycle write, 4-cycle pipelined read --------
    logic [15:0] mem_img [0:32767];
    logic [15:0] ref_img [0:32767];
    logic [3:0]  pv;
    logic [15:0] pd [0:3];

    always @(posedge clk) begin
        if (rst) begin
            pv <= 4'b0;
        end else begin
            pv    <= {pv[2:0], mem_en && !mem_wr};
            pd[0] <= mem_img[mem_addr[15:1]];
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
            if (mem_en && mem_wr) mem_img[mem_addr[15:1]] <= mem_wdata;
        end
    end
    assign mem_rvalid = pv[3];
    assign mem_rdata  = pv[3] ? pd[3] : 16'hDEAD;

    // ---------------- scoreboard state -------------------------------------
    typedef struct { bit wr; logic [15:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct { bit wr; int idx; logic [15:0] addr; logic [15:0] data; } ev_t;
    typedef struct { int t; logic [15:0] a; } iss_t;

    cmd_t icmd[$], dcmd[$];
    ev_t  iq[$], dq[$];
    iss_t iss_q[$];
    int   gap_q[$];
    bit   done_order[$];   // 1 = D, 0 = I
    int   n_vec = 0, n_err = 0;
    int   i_words = 0;
    int   last_done_cyc = 0;
    bit   prev_rd_en = 0;
    bit   i_done_flag = 0, d_done_flag = 0;
    bit   m_last_d = 0;    // model: side granted most recently

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not as expected (cycle %0d)", name, cyc);
    endtask

    task automatic check_issue(input logic [15:0] exp_addr);
        iss_t s;
        if (iss_q.size() == 0) begin
            miss("return_without_issue");
        end else begin
            s = iss_q.pop_front();
            chk("read_latency", 32'(cyc - s.t), 32'd4);
            chk("read_addr", 32'(s.a), 32'(exp_addr));
        end
    endtask

    // ---------------- monitor ----------------------------------------------
    ev_t mi, md;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en && !mem_wr) begin
                iss_q.push_back('{cyc, mem_addr});
                if (!prev_rd_en) gap_q.push_back(cyc - last_done_cyc);
            end
            prev_rd_en = mem_en && !mem_wr;

            // I side
            if (i_fill_valid) begin
                i_words++;
                if (iq.size() == 0) begin
                    miss("i_unexpected_fill");
                end else begin
                    mi = iq.pop_front();
                    chk("i_fill_idx", 32'(i_fill_idx), 32'(mi.idx));
                    chk("i_fill_data", 32'(i_fill_data), 32'(mi.data));
                    chk("i_done_at_last", 32'(i_done), 32'(mi.idx == 7));
                    check_issue(mi.addr);
                end
                if (i_done) begin
                    i_done_flag = 1;
                    done_order.push_back(1'b0);
                    last_done_cyc = cyc;
                end
            end else if (i_done) begin
                miss("i_done_without_fill");
            end else if (!i_req && iq.size() == 0 && icmd.size() == 0) begin
                chk("i_idle_zero", {12'd0, i_fill_idx, i_fill_data, i_done}, 32'd0);
            end

            // D side
            if (d_fill_valid) begin
                if (dq.size() == 0) begin
                    miss("d_unexpected_fill");
                end else begin
                    md = dq.pop_front();
                    chk("d_kind_fill", 32'(md.wr), 32'd0);
                    chk("d_fill_idx", 32'(d_fill_idx), 32'(md.idx));
                    chk("d_fill_data", 32'(d_fill_data), 32'(md.data));
                    chk("d_done_at_last", 32'(d_done), 32'(md.idx == 7));
                    check_issue(md.addr);
                end
                if (d_done) begin
                    d_done_flag = 1;
                    done_order.push_back(1'b1);
                    last_done_cyc = cyc;
                end
            end else if (d_done) begin
                if (dq.size() == 0) begin
                    miss("d_unexpected_done");
                end else begin
                    md = dq.pop_front();
                    chk("d_kind_write", 32'(md.wr), 32'd1);
                    chk("wr_mem_en_wr", {30'd0, mem_en, mem_wr}, 32'd3);
                    chk("wr_mem_addr", 32'(mem_addr), 32'(md.addr));
                    chk("wr_mem_wdata", 32'(mem_wdata), 32'(md.data));
                end
                d_done_flag = 1;
                done_order.push_back(1'b1);
                last_done_cyc = cyc;
            end else if (!d_req && dq.size() == 0 && dcmd.size() == 0) begin
                chk("d_idle_zero", {12'd0, d_fill_idx, d_fill_data, d_done}, 32'd0);
            end
            if (mem_en && mem_wr && !d_done) miss("mem_write_without_d_done");
        end
    end

    // ---------------- reference model / stimulus ---------------------------
    task automatic enq_fill(input bit side, input logic [15:0] a);
        cmd_t c;
        ev_t  e;
        int   base;
        c.wr = 0; c.addr = a; c.wdata = 16'(($urandom));
        base = (int'(a) / 16) * 16;
        for (int k = 0; k < 8; k++) begin
            e.wr = 0; e.idx = k;
            e.addr = 16'(base + 2 * k);
            e.data = ref_img[(base + 2 * k) / 2];
            if (side) dq.push_back(e); else iq.push_back(e);
        end
        if (side) dcmd.push_back(c); else icmd.push_back(c);
        m_last_d = side;
    endtask

    task automatic enq_write(input logic [15:0] a, input logic [15:0] w);
        cmd_t c;
        ev_t  e;
        c.wr = 1; c.addr = a; c.wdata = w;
        e.wr = 1; e.idx = 0; e.addr = 16'((int'(a) / 2) * 2); e.data = w;
        ref_img[int'(a) / 2] = w;
        dq.push_back(e);
        dcmd.push_back(c);
        m_last_d = 1;
    endtask

    function automatic bit tie_d();
`ifdef MEM_ARB_RR_EN
        return !m_last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        cmd_t c;
        @(posedge clk); #1;
        if (i_req && i_done_flag) begin i_done_flag = 0; i_req = 0; end
        if (!i_req && icmd.size() > 0) begin
            c = icmd.pop_front(); i_addr = c.addr; i_req = 1;
        end
        if (d_req && d_done_flag) begin d_done_flag = 0; d_req = 0; end
        if (!d_req && dcmd.size() > 0) begin
            c = dcmd.pop_front(); d_wr = c.wr; d_addr = c.addr; d_wdata = c.wdata; d_req = 1;
        end
    endtask

    task automatic do_reset();
        rst = 1; i_req = 0; d_req = 0;
        icmd.delete(); dcmd.delete(); iq.delete(); dq.delete(); iss_q.delete();
        i_done_flag = 0; d_done_flag = 0; m_last_d = 0; prev_rd_en = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((i_req || d_req || icmd.size() > 0 || dcmd.size() > 0 ||
                iq.size() > 0 || dq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            miss("drain_timeout");
            do_reset();
        end
        tick();
    endtask

    bit w;
    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem_img[i] = 16'($urandom);
            ref_img[i] = mem_img[i];
        end
        rst = 1; i_req = 0; d_req = 0; d_wr = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_i_outs", {12'd0, i_fill_valid, i_fill_idx, i_done, i_fill_data}, 32'd0);
        chk("reset_d_outs", {12'd0, d_fill_valid, d_fill_idx, d_done, d_fill_data}, 32'd0);
        chk("reset_mem_ctl", {30'd0, mem_en, mem_wr}, 32'd0);
        chk("reset_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        rst = 0;

        // I fill from a mid-block address
        enq_fill(0, 16'h1236);
        drain(100);

        // D write, then D fill of the same block sees the written word
        enq_write(16'h0041, 16'hBEEF);
        enq_fill(1, 16'h0040);
        drain(100);

        // Ties
        do_reset();
        w = tie_d();
        done_order.delete();
        enq_fill(w, w ? 16'h8100 : 16'h0100);
        enq_fill(!w, w ? 16'h0200 : 16'h8200);
        drain(100);
        chk("tie1_first", 32'(done_order.size() > 0 ? done_order[0] : !w), 32'(w));
        chk("tie1_second", 32'(done_order.size() > 1 ? done_order[1] : w), 32'(!w));
        enq_write(16'h8302, 16'h1234);
        drain(100);
        w = tie_d();
        done_order.delete();
        enq_fill(w, w ? 16'h8400 : 16'h0400);
        enq_fill(!w, w ? 16'h0500 : 16'h8500);
        drain(100);
        chk("tie2_first", 32'(done_order.size() > 0 ? done_order[0] : !w), 32'(w));
        chk("tie2_second", 32'(done_order.size() > 1 ? done_order[1] : w), 32'(!w));

        // Back-to-back D fills with req held
        gap_q.delete();
        enq_fill(1, 16'h9000);
        enq_fill(1, 16'h9010);
        drain(100);
        chk("b2b_gap", 32'(gap_q.size() > 1 ? gap_q[1] : -1), 32'd2);

        // I request arriving mid D fill waits and is served next
        gap_q.delete();
        done_order.delete();
        enq_fill(1, 16'hA000);
        repeat (5) tick();
        enq_fill(0, 16'h3000);
        drain(100);
        chk("wait_order_d", 32'(done_order.size() > 0 ? done_order[0] : 1'b0), 32'd1);
        chk("wait_order_i", 32'(done_order.size() > 1 ? done_order[1] : 1'b1), 32'd0);
        chk("wait_gap", 32'(gap_q.size() > 1 ? gap_q[1] : -1), 32'd2);

        // Reset during the third returned word abandons the fill
        i_words = 0;
        enq_fill(0, 16'h2468);
        tick();
        for (int n = 0; n < 40 && i_words < 3; n++) begin
            @(negedge clk); #1;
        end
        chk("reset_mid_words", 32'(i_words), 32'd3);
        rst = 1; i_req = 0;
        icmd.delete(); iq.delete(); iss_q.delete(); i_done_flag = 0;
        m_last_d = 0; prev_rd_en = 0;
        @(negedge clk); #1;
        chk("rst_mid_i_outs", {12'd0, i_fill_valid, i_fill_idx, i_done, i_fill_data}, 32'd0);
        chk("rst_mid_d_outs", {12'd0, d_fill_valid, d_fill_idx, d_done, d_fill_data}, 32'd0);
        chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
        rst = 0;
        repeat (12) tick();
        enq_fill(0, 16'h0100);
        drain(100);

        // Randomised traffic: I fills in the low half, D traffic in the high half
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: enq_fill(0, 16'($urandom) & 16'h7FFF);
                1: enq_write(16'($urandom) | 16'h8000, 16'($urandom));
                2: enq_fill(1, 16'($urandom) | 16'h8000);
                default: ;
            endcase
            repeat ($urandom_range(0, 6)) tick();
        end
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
